// File: rtl/acc_port_pkg.sv
// Shared definitions for the accelerator-side FIFO port: state encoding,
// default widths and the supported read-latency range.
package acc_port_pkg;
  localparam int DW_DEF     = 32;
  localparam int CW_DEF     = 32;
  localparam int RD_LAT_DEF = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/acc_skid_buf.sv
// Two-entry FIFO between the to-accelerator FIFO read data and the core.
// A push and a pop in the same cycle leave the occupancy unchanged.
module acc_skid_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);
  logic [1:0][DW-1:0] mem_q, mem_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop  = pop & (cnt_q != 2'd0);
    // a full buffer may still take a word when its head leaves this cycle
    do_push = push & ((cnt_q != 2'd2) | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
endmodule

// File: rtl/acc_fifo_port.sv
// Accelerator-side end of the router<->accelerator FIFO pair: fetches job words,
// feeds the core, returns results. ACC_FIFO_PORT_LOOPBACK_EN adds a loopback input.
module acc_fifo_port
  import acc_port_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
`ifdef ACC_FIFO_PORT_LOOPBACK_EN
  input  logic          loopback,
`endif
  input  logic          start,
  input  logic [CW-1:0] num_words,
  output logic          busy,
  output logic          done,
  input  logic          in_empty,
  output logic          in_req_get,
  input  logic [DW-1:0] in_data,
  output logic          core_valid,
  input  logic          core_ready,
  output logic [DW-1:0] core_data,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [DW-1:0] res_data,
  input  logic          out_full,
  output logic          out_req_put,
  output logic [DW-1:0] out_data
);
  state_e            state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     fetched_q, fetched_d;
  logic [CW-1:0]     returned_q, returned_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;

  logic [1:0]    buf_cnt, inflight;
  logic [DW-1:0] buf_head;
  logic          buf_push, buf_pop, buf_valid;
  logic          run, lb, ret_open, put_res, put_loop;

`ifdef ACC_FIFO_PORT_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = 1'b0;
`endif

  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {1'b0, pipe_q[i]};
  end

  // Words already requested count against the buffer so a returning word always fits.
  assign run        = (state_q == ST_RUN);
  assign in_req_get = run & ~in_empty & (fetched_q < n_q) &
                      (({1'b0, buf_cnt} + {1'b0, inflight}) < 3'd2);
  assign buf_push   = pipe_q[RD_LAT-1];
  assign buf_valid  = (buf_cnt != 2'd0);

  assign ret_open    = run & ~out_full & (returned_q < n_q);
  assign core_valid  = buf_valid & ~lb;
  assign core_data   = core_valid ? buf_head : '0;
  assign put_loop    = lb & buf_valid & ret_open;
  assign res_ready   = ret_open & ~lb;
  assign put_res     = res_valid & res_ready;
  assign buf_pop     = put_loop | (core_valid & core_ready);
  assign out_req_put = put_loop | put_res;
  assign out_data    = put_loop ? buf_head : (put_res ? res_data : '0);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  always_comb begin
    pipe_d[0] = in_req_get;
    for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    fetched_d  = fetched_q;
    returned_d = returned_q;
    if (in_req_get)  fetched_d  = fetched_q + CW'(1);
    if (out_req_put) returned_d = returned_q + CW'(1);
    case (state_q)
      ST_IDLE: if (start) begin
        n_d        = num_words;
        fetched_d  = '0;
        returned_d = '0;
        state_d    = (num_words == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:  if ((fetched_q == n_q) && (returned_q == n_q)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      fetched_q  <= '0;
      returned_q <= '0;
      pipe_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      fetched_q  <= fetched_d;
      returned_q <= returned_d;
      pipe_q     <= pipe_d;
    end
  end

  acc_skid_buf #(.DW(DW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (in_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_cnt)
  );
endmodule

// File: tb/tb_acc_fifo_port.sv
// Bench for acc_fifo_port: FIFO and echoing-core models around the DUT, a
// job table plus a mid-job reset sequence, scoreboarded words and results.
module tb_acc_fifo_port;
  localparam int DW = 32;
  localparam int CW = 32;
  localparam logic [DW-1:0] RES_XOR = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [CW-1:0] num_words;
  logic          busy, done, in_empty, in_req_get;
  logic [DW-1:0] in_data, core_data, res_data, out_data;
  logic          core_valid, core_ready, res_valid, res_ready, out_full, out_req_put;

  always #5 clk = ~clk;

  acc_fifo_port #(.DW(DW), .CW(CW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
`ifdef ACC_FIFO_PORT_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .start(start), .num_words(num_words), .busy(busy), .done(done),
    .in_empty(in_empty), .in_req_get(in_req_get), .in_data(in_data),
    .core_valid(core_valid), .core_ready(core_ready), .core_data(core_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .out_full(out_full), .out_req_put(out_req_put), .out_data(out_data)
  );

  int vecs = 0, errs = 0;
  logic [DW-1:0] in_fifo[$], exp_core[$], exp_out[$], res_pend[$];
  int   in_cnt = 0, res_cnt = 0, cyc_n = 0;
  int   gets = 0, pops = 0, puts = 0, done_cnt = 0, done_cyc = 0;
  logic in_gate = 1'b0, tog_en = 1'b0, res_en = 1'b1;
  logic [DW-1:0] res_head = '0;

  assign in_empty  = (in_cnt == 0) || in_gate;
  assign res_valid = (res_cnt > 0) && res_en;
  assign res_data  = res_head;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic flag(input string nm);
    errs++;
    $display("FAIL %s: protocol violation (cycle %0d)", nm, cyc_n);
  endtask

  // FIFO / core models: sample handshakes mid-cycle, apply effects just after the edge.
  logic s_get, s_core, s_take;
  logic [DW-1:0] s_word;
  always begin
    @(negedge clk);
    s_get  = in_req_get;
    s_core = core_valid && core_ready;
    s_take = res_valid && res_ready;
    s_word = core_data;
    if (in_req_get && in_empty) flag("get_while_empty");
    if (out_full && (res_ready || out_req_put)) flag("put_while_full");
    if (s_take !== out_req_put) flag("put_vs_handshake");
    if (s_core) begin
      if (exp_core.size() == 0) flag("core_unexpected");
      else begin
        chk("core_data", {32'd0, core_data}, {32'd0, exp_core[0]});
        exp_out.push_back(exp_core[0] ^ RES_XOR);
        void'(exp_core.pop_front());
      end
    end
    if (out_req_put) begin
      if (exp_out.size() == 0) flag("put_unexpected");
      else begin
        chk("out_data", {32'd0, out_data}, {32'd0, exp_out[0]});
        void'(exp_out.pop_front());
      end
    end
    if (done) begin done_cnt++; done_cyc = cyc_n; end
    gets += int'(s_get);
    pops += int'(s_core);
    puts += int'(out_req_put);
    if (gets - pops > 2) flag("outstanding_gt2");
    @(posedge clk);
    #1;
    cyc_n++;
    if (s_get && in_cnt > 0) begin
      in_data = in_fifo.pop_front();
      in_cnt  = in_fifo.size();
    end
    if (s_take && res_pend.size() > 0) void'(res_pend.pop_front());
    if (s_core) res_pend.push_back(s_word ^ RES_XOR);
    res_cnt  = res_pend.size();
    res_head = (res_cnt > 0) ? res_pend[0] : '0;
    if (tog_en) in_gate = ~in_gate;
    else        in_gate = 1'b0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int n;
    int stall;
    bit tog;
    int full;
    int exp_get;
    int exp_put;
  } vec_t;

  task automatic run_job(input vec_t v);
    int k;
    logic [DW-1:0] w;
    gets = 0; pops = 0; puts = 0; done_cnt = 0;
    for (int i = 0; i < v.n; i++) begin
      w = $urandom;
      in_fifo.push_back(w);
      exp_core.push_back(w);
    end
    in_cnt     = in_fifo.size();
    core_ready = (v.stall == 0);
    out_full   = (v.full > 0);
    tog_en     = v.tog;
    start      = 1'b1;
    num_words  = CW'(v.n);
    cyc();
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (k = 0; k < 600; k++) begin
      if (k == v.stall) core_ready = 1'b1;
      if (k == v.full)  out_full = 1'b0;
      if (v.stall > 0 && k == v.stall - 1) chk("gets_during_stall", gets, 2);
      if (v.full > 0 && k == v.full - 1)   chk("puts_during_full", puts, 0);
      cyc();
      if (done_cnt > 0) break;
    end
    if (k == 600) flag("done_timeout");
    if (v.n == 0) begin
      vecs++;
      if (done_cyc - (cyc_n - k - 1) < 1 || done_cyc - (cyc_n - k - 1) > 2) begin
        errs++;
        $display("FAIL n0_latency: got %0d expected 1..2", done_cyc - (cyc_n - k - 1));
      end
    end
    repeat (3) cyc();
    tog_en = 1'b0;
    chk("gets",      gets, v.exp_get);
    chk("puts",      puts, v.exp_put);
    chk("done_once", done_cnt, 1);
    chk("words_left", exp_core.size() + exp_out.size(), 0);
    chk("busy_idle", {63'd0, busy}, 64'd0);
  endtask

  vec_t vt[5];

  initial begin : main
    int k;
    vt[0] = '{4, 0, 1'b0, 0, 4, 4};
    vt[1] = '{8, 10, 1'b0, 0, 8, 8};
    vt[2] = '{8, 0, 1'b1, 0, 8, 8};
    vt[3] = '{6, 0, 1'b0, 12, 6, 6};
    vt[4] = '{0, 0, 1'b0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; num_words = '0; in_data = '0;
    core_ready = 1'b1; out_full = 1'b0;
    repeat (3) cyc();
    chk("reset_outputs",
        {busy, done, in_req_get, core_valid, res_ready, out_req_put, core_data, out_data}, 64'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 5; i++) run_job(vt[i]);

    // reset in the middle of an 8-word job, after 3 words reach the core
    gets = 0; pops = 0; puts = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_fifo.push_back(32'h1000 + 32'(i));
      exp_core.push_back(32'h1000 + 32'(i));
    end
    in_cnt = in_fifo.size();
    core_ready = 1'b1;
    start = 1'b1; num_words = 8;
    cyc();
    start = 1'b0;
    for (k = 0; k < 200 && pops < 3; k++) cyc();
    if (k == 200) flag("abort_wait_timeout");
    reset = 1'b1;
    cyc();
    chk("abort_outputs",
        {busy, done, in_req_get, core_valid, res_ready, out_req_put, core_data, out_data}, 64'd0);
    chk("abort_no_done", done_cnt, 0);
    #1;
    in_fifo.delete(); exp_core.delete(); exp_out.delete(); res_pend.delete();
    in_cnt = 0; res_cnt = 0; res_head = '0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_abort_idle", {63'd0, busy}, 64'd0);
    run_job('{2, 0, 1'b0, 0, 2, 2});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
